// File: rtl/truncamiento_signo.sv
// rtl/truncamiento_signo.sv - store-path narrowing: truncate, flag loss, serialize bytes to memory
module truncamiento_signo #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dato,
    input  logic [1:0]  tam,
    input  logic [31:0] dir,
    output logic        busy,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_dato,
    input  logic        mem_ack,
    output logic        listo,
    output logic        desborde,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, ENVIO, FIN} estado_t;

    estado_t     state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;       // index of the final byte (n-1)
    logic [31:0] dato_q, dato_d;
    logic [31:0] dir_q, dir_d;
    logic        err_q, err_d;
    logic        desb_q, desb_d;

    logic        busy_q, busy_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_dato_q, mem_dato_d;
    logic        listo_q, listo_d;
    logic        desborde_q, desborde_d;
    logic        error_q, error_d;

    logic        acc_err;
    logic        acc_desb;
    logic [1:0]  idx;

    // Next-state logic; outputs are decoded from the next state so they leave flops
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        dato_d   = dato_q;
        dir_d    = dir_q;
        err_d    = err_q;
        desb_d   = desb_q;
        acc_err  = (tam == 2'b11) ||
                   (tam == 2'b01 && dir[0]) ||
                   (tam == 2'b10 && dir[1:0] != 2'b00);
        acc_desb = 1'b0;
        case (tam)
            2'b00:   acc_desb = (dato[31:8]  != {24{dato[7]}});
            2'b01:   acc_desb = (dato[31:16] != {16{dato[15]}});
            default: acc_desb = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    dato_d  = dato;
                    dir_d   = dir;
                    cnt_d   = 2'd0;
                    last_d  = (tam == 2'b00) ? 2'd0 : (tam == 2'b01) ? 2'd1 : 2'd3;
                    err_d   = acc_err;
                    desb_d  = acc_err ? 1'b0 : acc_desb;
                    state_d = acc_err ? FIN : ENVIO;
                end
            end
            ENVIO: begin
                if (mem_ack) begin
                    if (cnt_q == last_q) begin
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        idx = BIG_ENDIAN ? (last_d - cnt_d) : cnt_d;

        busy_d     = (state_d != IDLE);
        mem_we_d   = (state_d == ENVIO);
        mem_addr_d = 32'd0;
        mem_dato_d = 8'd0;
        if (state_d == ENVIO) begin
            mem_addr_d = dir_d + {30'd0, cnt_d};
            case (idx)
                2'd0:    mem_dato_d = dato_d[7:0];
                2'd1:    mem_dato_d = dato_d[15:8];
                2'd2:    mem_dato_d = dato_d[23:16];
                default: mem_dato_d = dato_d[31:24];
            endcase
        end
        listo_d    = (state_d == FIN);
        error_d    = (state_d == FIN) && err_d;
        desborde_d = (state_d == FIN) && desb_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            dato_q     <= 32'd0;
            dir_q      <= 32'd0;
            err_q      <= 1'b0;
            desb_q     <= 1'b0;
            busy_q     <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_dato_q <= 8'd0;
            listo_q    <= 1'b0;
            desborde_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            dato_q     <= dato_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            desb_q     <= desb_d;
            busy_q     <= busy_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_dato_q <= mem_dato_d;
            listo_q    <= listo_d;
            desborde_q <= desborde_d;
            error_q    <= error_d;
        end
    end

    assign busy     = busy_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_dato = mem_dato_q;
    assign listo    = listo_q;
    assign desborde = desborde_q;
    assign error    = error_q;

endmodule

// File: tb/tb_truncamiento_signo.sv
// tb/tb_truncamiento_signo.sv - self-checking bench for truncamiento_signo
module tb_truncamiento_signo;

    logic        clk = 1'b0;
    logic        rst, start, mem_ack;
    logic [31:0] dato, dir;
    logic [1:0]  tam;

    logic        b_busy, b_we, b_listo, b_desb, b_err;
    logic [31:0] b_addr;
    logic [7:0]  b_dato;
    logic        l_busy, l_we, l_listo, l_desb, l_err;
    logic [31:0] l_addr;
    logic [7:0]  l_dato;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    truncamiento_signo #(.BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst), .start(start), .dato(dato), .tam(tam), .dir(dir),
        .busy(b_busy), .mem_we(b_we), .mem_addr(b_addr), .mem_dato(b_dato),
        .mem_ack(mem_ack), .listo(b_listo), .desborde(b_desb), .error(b_err)
    );

    truncamiento_signo #(.BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst(rst), .start(start), .dato(dato), .tam(tam), .dir(dir),
        .busy(l_busy), .mem_we(l_we), .mem_addr(l_addr), .mem_dato(l_dato),
        .mem_ack(mem_ack), .listo(l_listo), .desborde(l_desb), .error(l_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One store from accept to the idle cycle after listo; entered and left at posedge+1
    task automatic run(input logic [31:0] d, input logic [1:0] t, input logic [31:0] a,
                       input int stall_idx, input int stall_n);
        int n, wcount, stall_left, exp_lat, k;
        logic exp_err, exp_desb, done;
        logic signed [7:0]  s8;
        logic signed [15:0] s16;
        logic signed [31:0] sx;
        logic [7:0] exp_be[4];
        logic [7:0] exp_le[4];
        n = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
        exp_err = (t == 2'd3) || (t == 2'd1 && a % 2 != 0) || (t == 2'd2 && a % 4 != 0);
        s8 = d[7:0];
        s16 = d[15:0];
        if (t == 2'd0) sx = s8;
        else if (t == 2'd1) sx = s16;
        else sx = $signed(d);
        exp_desb = !exp_err && (sx != $signed(d));
        for (int i = 0; i < 4; i++) begin
            exp_be[i] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
            exp_le[i] = 8'((d >> (8 * i)) & 32'hFF);
        end
        exp_lat = exp_err ? 1 : n + 1 + ((stall_idx < n) ? stall_n : 0);

        start = 1'b1; dato = d; tam = t; dir = a; mem_ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dato = $urandom; tam = 2'($urandom); dir = $urandom;
        wcount = 0; stall_left = stall_n; done = 1'b0;
        for (k = 1; k <= 20 && !done; k++) begin
            if (b_listo) begin
                chk("latency", 32'(k), 32'(exp_lat));
                chk("error", {31'd0, b_err}, {31'd0, exp_err});
                chk("desborde", {31'd0, b_desb}, {31'd0, exp_desb});
                chk("le_listo", {31'd0, l_listo}, 32'd1);
                chk("writes", 32'(wcount), exp_err ? 32'd0 : 32'(n));
                start = 1'b0;
                done = 1'b1;
            end else begin
                if (b_we) begin
                    if (wcount >= n || exp_err) begin
                        chk("extra_write", 32'd1, 32'd0);
                        mem_ack = 1'b1;
                    end else begin
                        chk("be_addr", b_addr, a + 32'(wcount));
                        chk("be_data", {24'd0, b_dato}, {24'd0, exp_be[wcount]});
                        chk("le_data", {24'd0, l_dato}, {24'd0, exp_le[wcount]});
                        if (wcount == stall_idx && stall_left > 0) begin
                            mem_ack = 1'b0;
                            stall_left--;
                        end else begin
                            mem_ack = 1'b1;
                            wcount++;
                        end
                    end
                end else begin
                    chk("we_in_envio", {31'd0, b_we}, 32'd1);
                    mem_ack = 1'b1;
                end
                // a second request while busy must be ignored
                start = (k == 2);
                dato = $urandom;
                @(posedge clk); #1;
            end
        end
        if (!done) chk("listo_timeout", 32'd0, 32'd1);
        start = 1'b0; mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", {31'd0, b_busy}, 32'd0);
        chk("idle_listo", {31'd0, b_listo}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, ra;
        logic [1:0]  rt;
        int seen;
        rst = 1'b1; start = 1'b0; mem_ack = 1'b1; dato = 32'd0; tam = 2'd0; dir = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, b_busy}, 32'd0);
        chk("rst_we", {31'd0, b_we}, 32'd0);
        chk("rst_addr", b_addr, 32'd0);
        chk("rst_data", {24'd0, b_dato}, 32'd0);
        chk("rst_flags", {29'd0, b_listo, b_desb, b_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(32'h0000_0041, 2'b00, 32'h10, 9, 0);
        run(32'h0001_8000, 2'b01, 32'h20, 9, 0);
        run(32'hDEAD_BEEF, 2'b10, 32'h100, 1, 2);
        run(32'h1234_5678, 2'b11, 32'h40, 9, 0);
        run(32'h0000_1234, 2'b01, 32'h21, 9, 0);
        run(32'hCAFE_F00D, 2'b10, 32'h102, 9, 0);
        run(32'hFFFF_FF80, 2'b00, 32'h33, 9, 0);
        run(32'h0000_0180, 2'b00, 32'h34, 9, 0);
        run(32'hFFFF_8001, 2'b01, 32'hFFFF_FFFE, 0, 1);

        // Reset during the third byte of a word store
        start = 1'b1; dato = 32'h1122_3344; tam = 2'b10; dir = 32'h200; mem_ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 6 && seen < 3; k++) begin
            if (b_we) seen++;
            start = (k == 1);
            if (seen < 3) begin
                @(posedge clk); #1;
            end
        end
        chk("rst_mid_third", {24'd0, b_dato}, 32'h33);
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, b_busy}, 32'd0);
        chk("abort_we", {31'd0, b_we}, 32'd0);
        chk("abort_listo", {31'd0, b_listo}, 32'd0);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (b_we || b_listo || l_we || l_listo) seen++;
        end
        chk("abort_quiet", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rt = 2'($urandom_range(0, 3));
            rd = $urandom;
            if ($urandom_range(0, 1) == 1) rd = (rt == 2'b00) ? {{24{rd[7]}}, rd[7:0]} : {{16{rd[15]}}, rd[15:0]};
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra = ra & ~32'h3;
            run(rd, rt, ra, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
